// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection with redirect and
// stall handling, and the IF/ID pipeline register with a fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IM_Address,
  input  logic [31:0] IM_Instruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        bubble;
  logic        load;

  // Branch wins over jump when both fire; targets are forced word-aligned.
  always_comb begin
    pc_plus4   = pc + 32'd4;
    redirect   = BranchTaken | Jump;
    target_raw = BranchTaken ? BranchTarget : JumpTarget;
    target     = {target_raw[31:2], 2'b00};
    bubble     = Flush | redirect;
    load       = ~bubble & ~Stall;
  end

  assign IM_Address = pc;

  // PC update: a redirect overrides a stall; a flush alone lets the PC advance.
  always_ff @(posedge Clk) begin
    if (Rst)           pc <= RESET_PC;
    else if (redirect) pc <= target;
    else if (!Stall)   pc <= pc_plus4;
  end

  // IF/ID register: bubble beats stall, stall holds, otherwise capture the fetch.
  always_ff @(posedge Clk) begin
    if (Rst || bubble) begin
      IFID_Instruction <= 32'h0;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (load) begin
      IFID_Instruction <= IM_Instruction;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
    end
  end

  // Count only edges that capture a real instruction; wraps naturally.
  always_ff @(posedge Clk) begin
    if (Rst)       FetchCount <= 32'h0;
    else if (load) FetchCount <= FetchCount + 32'd1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (reset PC 0 and 0xFFFFFFFC)
// share stimulus; a reference model pushes expected post-edge state into
// queues and a monitor pops and compares after each rising edge.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] cnt;
  } st_t;

  logic        Clk;
  logic        Rst, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] addr0, addr1, im0, im1;
  logic [31:0] ins0, ins1, p40, p41, cnt0, cnt1;
  logic        val0, val1;

  int n_cmp = 0;
  int n_bad = 0;
  st_t q0[$];
  st_t q1[$];
  st_t m0, m1;

  function automatic logic [31:0] im_word(logic [31:0] a);
    return 32'h1000 + a;
  endfunction

  assign im0 = im_word(addr0);
  assign im1 = im_word(addr1);

  fetch_stage #(.RESET_PC(32'h00000000)) dut0 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .IM_Address(addr0), .IM_Instruction(im0),
    .IFID_Instruction(ins0), .IFID_PCPlus4(p40), .IFID_Valid(val0),
    .FetchCount(cnt0)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut1 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .IM_Address(addr1), .IM_Instruction(im1),
    .IFID_Instruction(ins1), .IFID_PCPlus4(p41), .IFID_Valid(val1),
    .FetchCount(cnt1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: state after one rising edge, from the rules in plain terms.
  function automatic st_t model_step(st_t s, logic [31:0] rpc, logic rst, logic stall,
                                     logic flush, logic br, logic [31:0] bt,
                                     logic j, logic [31:0] jt);
    st_t n;
    logic [31:0] tgt;
    n = s;
    if (rst) begin
      n.pc = rpc; n.instr = 0; n.pcp4 = 0; n.valid = 0; n.cnt = 0;
      return n;
    end
    tgt = br ? bt : jt;
    tgt = tgt & 32'hFFFFFFFC;
    if (br || j)   n.pc = tgt;
    else if (!stall) n.pc = s.pc + 4;
    if (flush || br || j) begin
      n.instr = 0; n.pcp4 = 0; n.valid = 0;
    end else if (!stall) begin
      n.instr = im_word(s.pc);
      n.pcp4  = s.pc + 4;
      n.valid = 1;
      n.cnt   = s.cnt + 1;
    end
    return n;
  endfunction

  task automatic drive(logic rst, logic stall, logic flush, logic br,
                       logic [31:0] bt, logic j, logic [31:0] jt);
    @(negedge Clk);
    Rst = rst; Stall = stall; Flush = flush;
    BranchTaken = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
    m0 = model_step(m0, 32'h00000000, rst, stall, flush, br, bt, j, jt);
    m1 = model_step(m1, 32'hFFFFFFFC, rst, stall, flush, br, bt, j, jt);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic free_run(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor: after each edge, compare both instances against queued expectations.
  initial begin
    st_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_im_address", addr0, e.pc);
        chk("d0_ifid_instr", ins0, e.instr);
        chk("d0_ifid_pcplus4", p40, e.pcp4);
        chk("d0_ifid_valid", {31'h0, val0}, {31'h0, e.valid});
        chk("d0_fetch_count", cnt0, e.cnt);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_im_address", addr1, e.pc);
        chk("d1_ifid_instr", ins1, e.instr);
        chk("d1_ifid_pcplus4", p41, e.pcp4);
        chk("d1_ifid_valid", {31'h0, val1}, {31'h0, e.valid});
        chk("d1_fetch_count", cnt1, e.cnt);
      end
    end
  end

  initial begin
    int budget;
    m0 = '{pc: 0, instr: 0, pcp4: 0, valid: 0, cnt: 0};
    m1 = m0;
    Rst = 1; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
    BranchTarget = 0; JumpTarget = 0;

    // Reset, three free cycles (also covers the 0xFFFFFFFC wrap on dut1).
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    free_run(3);
    // Stall held two cycles at PC=8, then release.
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    free_run(2);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    free_run(1);
    // Branch with stall high, misaligned target.
    drive(0, 1, 0, 1, 32'h00000043, 0, 32'h0);
    free_run(1);
    // Branch and jump together: branch wins.
    drive(0, 0, 0, 1, 32'h00000080, 1, 32'h00000100);
    free_run(1);
    // Jump alone, then flush alone.
    drive(0, 0, 0, 0, 32'h0, 1, 32'h00000207);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    free_run(4);
    // Reset while stalled and mid-redirect.
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    drive(1, 1, 0, 1, 32'h00000500, 0, 32'h0);
    free_run(2);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
            ($urandom % 7) == 0, $urandom, ($urandom % 7) == 0, $urandom);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);

    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0) && budget < 10) begin
      @(posedge Clk);
      budget++;
    end
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: actual=%0d pending required=0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
